ififo_skew_feeder: RTL and testbench
====================================

Name: ififo_skew_feeder

Overview:
- Sits directly downstream of the input FIFO and directly upstream of the systolic MAC array's west edge.
- On `start`, pops `len` column vectors from the FIFO and delays lane k by k extra cycles, so data enters the array on the required diagonal wavefront.
- Drives per-lane valids, inserts bubbles on FIFO underflow, and pulses `done` when the last lane of the last vector has been presented.

Parameters:
- col, 8, number of lanes (array rows fed); equals FIFO vector lane count.
- bw, 4, bits per lane.
- lw, 8, width of the `len` field and the remaining-vector counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle request to begin a stream; ignored while busy.
- len  input  lw  number of vectors to stream; sampled on accepted start.
- fifo_out  input  col*bw  FIFO head vector (combinational from FIFO read pointer).
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd  output  1  FIFO pop; head vector is captured on the same edge.
- array_in  output  col*bw  skewed lane data; lane k = bits [k*bw +: bw].
- array_valid  output  col  per-lane valid.
- busy  output  1  high from accepted start until done cycle inclusive.
- done  output  1  one-cycle completion pulse.
- stall_cnt  output  16  count of underflow bubble cycles in the current/last stream.

Behaviour:
- Reset (reset=0, immediate, no clock needed): state IDLE.
  - fifo_rd, busy, done = 0.
  - All delay-line data and valid bits = 0, so array_in = 0 and array_valid = 0.
  - remaining = 0, stall_cnt = 0.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE: start=1 latches remaining=len and clears stall_cnt.
  - len != 0 → STREAM.
  - len == 0 → DONE, with no pops.
- STREAM:
  - fifo_rd = !fifo_empty && remaining != 0 (combinational).
  - On a pop edge: capture fifo_out with valid=1 into the stage-0 registers of all lanes, and decrement remaining.
  - Underflow cycle (fifo_empty=1): no pop; a bubble (data 0, valid 0) enters stage 0; stall_cnt increments, saturating at 16'hFFFF.
  - The edge that pops the final vector (remaining 1→0) moves to DRAIN and loads drain_cnt = col-1.
- DRAIN:
  - fifo_rd = 0; bubbles enter stage 0.
  - drain_cnt decrements each edge; at drain_cnt==0 the next edge moves to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then → IDLE. A start in this cycle is ignored.
- Skew and latency:
  - Lane k has total latency k+1 edges from its pop edge.
  - Lane 0 is visible the cycle after the pop; lane col-1 is visible col cycles after the pop.
  - Each lane's data and valid travel together.
- Data gating: whenever array_valid[k]=0, array_in lane k = 0. The MACs therefore never see stale data.
- Cycle accounting: with a last pop at edge E, the DONE cycle follows edge E+col, i.e. one cycle after lane col-1 of the final vector is presented.
- Back-to-back vectors with no underflow produce contiguous valids on every lane.
- start while busy: ignored; len is not resampled.
- Reset mid-stream: the stream is abandoned with no partial done; the FIFO is not popped again until a new start.
- Arithmetic:
  - remaining and drain_cnt are unsigned and never wrap below 0.
  - stall_cnt saturates rather than wrapping.

Decomposition:
- Shared package ififo_feeder_pkg holds:
  - FSM state encoding (IDLE=0, STREAM=1, DRAIN=2, DONE=3).
  - STALL_W=16.
  - Lane-slice helper constants.
- One natural sub-module: skew_delay_line.
  - Parameters: depth, bw.
  - Function: shift register of {valid, data} with async active-low clear.
  - Instantiated col times with depth = k+1.

Test Plan:
- Preload FIFO with 4 vectors, lanes = {lane index + vector index}; start, len=4 → fifo_rd high 4 consecutive cycles. Lane 0 valid cycles 1–4 after the first pop; lane 7 valid cycles 8–11. done pulses once, 12 cycles after the first pop; stall_cnt=0.
- FIFO holds 2 vectors, len=4, third vector written 3 cycles later → exactly 3 bubble cycles. array_valid shows a 3-cycle gap propagating diagonally through lanes 0–7; stall_cnt=3; done still pulses once after vector 4 drains.
- start with len=0 → no fifo_rd; done=1 exactly one cycle after start; busy high for that cycle only; array_valid stays 0.
- Second start pulse mid-STREAM with len=9 → ignored: exactly the original len pops occur and one done pulse.
- Assert reset=0 asynchronously, 2 cycles into a len=6 stream → outputs clear immediately without a clock edge: array_valid=0, array_in=0, fifo_rd=0, busy=0. After release, remaining FIFO contents stay unpopped until a new start.
- Force stall_cnt near saturation (long empty FIFO, len=1, 70000 cycles) → stall_cnt holds 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/ififo_feeder_pkg.sv
// Shared state encoding and constants for the input-FIFO skew feeder.
package ififo_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  localparam int STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  // Bit offset of a lane inside a packed column vector.
  function automatic int lane_lsb(input int lane, input int lane_bw);
    return lane * lane_bw;
  endfunction

endpackage

// File: rtl/ififo_skew_feeder_skew_delay_line.sv
// Per-lane shift register of {valid, data}; data is zeroed whenever valid is low.
module skew_delay_line #(
  parameter int depth = 1,
  parameter int bw    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [bw-1:0] d_data,
  output logic          q_valid,
  output logic [bw-1:0] q_data
);

  logic [bw:0] stage [depth];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) stage[i] <= '0;
    end else begin
      stage[0] <= {d_valid, (d_valid ? d_data : {bw{1'b0}})};
      for (int i = 1; i < depth; i++) stage[i] <= stage[i-1];
    end
  end

  assign q_valid = stage[depth-1][bw];
  assign q_data  = stage[depth-1][bw-1:0];

endmodule

// File: rtl/ififo_skew_feeder.sv
// Pops column vectors from the input FIFO and presents them to the array
// west edge on a diagonal wavefront (lane k delayed by k extra cycles).
module ififo_skew_feeder
  import ififo_feeder_pkg::*;
#(
  parameter int col = 8,
  parameter int bw  = 4,
  parameter int lw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [lw-1:0]      len,
  input  logic [col*bw-1:0]  fifo_out,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  output logic [col*bw-1:0]  array_in,
  output logic [col-1:0]     array_valid,
  output logic               busy,
  output logic               done,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int DW = (col > 1) ? $clog2(col) : 1;

  feeder_state_t state;
  logic [lw-1:0] remaining;
  logic [DW-1:0] drain_cnt;

  assign fifo_rd = (state == STREAM) && !fifo_empty && (remaining != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      drain_cnt <= '0;
      stall_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= len;
            stall_cnt <= '0;
            busy      <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (fifo_rd) begin
            remaining <= remaining - 1'b1;
            // Final pop: wait for it to reach the deepest lane.
            if (remaining == lw'(1)) begin
              state     <= DRAIN;
              drain_cnt <= DW'(col - 1);
            end
          end else if (fifo_empty && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    localparam int lsb = lane_lsb(gi, bw);
    logic          lane_valid;
    logic [bw-1:0] lane_data;

    skew_delay_line #(.depth(gi + 1), .bw(bw)) u_delay (
      .clk     (clk),
      .reset   (reset),
      .d_valid (fifo_rd),
      .d_data  (fifo_out[lsb +: bw]),
      .q_valid (lane_valid),
      .q_data  (lane_data)
    );

    assign array_valid[gi]     = lane_valid;
    assign array_in[lsb +: bw] = lane_valid ? lane_data : '0;
  end

endmodule

// File: tb/tb_ififo_skew_feeder.sv
// Bench for ififo_skew_feeder: FIFO environment plus a cycle-indexed schedule model.
module tb_ififo_skew_feeder;

  localparam int COL = 8;
  localparam int BW  = 4;
  localparam int LW  = 8;
  localparam int VW  = COL * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [VW-1:0] fifo_out;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [VW-1:0] array_in;
  logic [COL-1:0] array_valid;
  logic          busy;
  logic          done;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  ififo_skew_feeder #(.col(COL), .bw(BW), .lw(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len),
    .fifo_out    (fifo_out),
    .fifo_empty  (fifo_empty),
    .fifo_rd     (fifo_rd),
    .array_in    (array_in),
    .array_valid (array_valid),
    .busy        (busy),
    .done        (done),
    .stall_cnt   (stall_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [VW-1:0] fq [$];

  // Model: hv/hd[e] = what the pop decided before edge e delivered; lane k at cycle t shows entry t-k.
  longint        cyc;
  bit            m_busy, m_stream;
  int            m_left, m_stalls;
  longint        m_done_cycle;
  bit            hv [16];
  logic [VW-1:0] hd [16];
  int            rd_count, done_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_out   = fifo_empty ? VW'($urandom) : fq[0];
  endtask

  task automatic push(input logic [VW-1:0] v);
    fq.push_back(v);
    refresh_fifo();
  endtask

  function automatic logic [VW-1:0] idx_vec(input int v);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = BW'(k + v);
    return r;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_stream = 0; m_left = 0; m_stalls = 0; m_done_cycle = -1;
    for (int i = 0; i < 16; i++) begin hv[i] = 0; hd[i] = '0; end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_fifo_rd"}, fifo_rd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, array_valid, 0);
    check({tag, "_array_in"}, array_in, 0);
    check({tag, "_stall"}, stall_cnt, 0);
  endtask

  // One clock cycle: check outputs, take the edge, advance the model and FIFO.
  task automatic step();
    logic [VW-1:0]  head, ed;
    logic [COL-1:0] ev;
    bit pop, accept, empty, rd_obs;
    int e;
    #1;
    empty = (fq.size() == 0);
    pop   = m_stream && !empty && (m_left != 0);
    for (int k = 0; k < COL; k++) begin
      e = int'((cyc - k) % 16);
      ev[k] = hv[e];
      ed[k*BW +: BW] = hv[e] ? hd[e][k*BW +: BW] : '0;
    end
    check("fifo_rd", fifo_rd, pop);
    check("busy", busy, m_busy);
    check("done", done, m_busy && (cyc == m_done_cycle));
    check("stall_cnt", stall_cnt, m_stalls);
    check("array_valid", array_valid, ev);
    check("array_in", array_in, ed);
    rd_obs = fifo_rd;
    if (fifo_rd) rd_count++;
    if (done) done_count++;
    accept = !m_busy && start;
    head   = empty ? '0 : fq[0];
    @(posedge clk);
    #1;
    if (m_busy && cyc == m_done_cycle) m_busy = 0;
    cyc++;
    hv[int'(cyc % 16)] = pop;
    hd[int'(cyc % 16)] = head;
    if (accept) begin
      m_busy = 1; m_left = int'(len); m_stalls = 0;
      if (len == 0) m_done_cycle = cyc;
      else m_stream = 1;
    end else if (m_stream) begin
      if (pop) begin
        m_left--;
        if (m_left == 0) begin
          m_stream = 0;
          m_done_cycle = cyc + COL;
        end
      end else if (m_stalls < 65535) begin
        m_stalls++;
      end
    end
    if (rd_obs && fq.size() != 0) void'(fq.pop_front());
    start = 1'b0;
    refresh_fifo();
    @(negedge clk);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    for (int i = 0; i < budget && m_busy; i++) step();
    check({tag, "_finished"}, busy, 0);
  endtask

  initial begin
    int n_len, pushed;
    cyc = 16;
    rd_count = 0; done_count = 0;
    model_clear();
    refresh_fifo();

    // Reset asserted from time zero.
    #1;
    check_cleared("reset");
    #12;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) step();

    // Four preloaded vectors, contiguous stream.
    for (int v = 0; v < 4; v++) push(idx_vec(v));
    rd_count = 0; done_count = 0;
    start = 1'b1; len = 8'd4;
    step();
    repeat (14) step();
    check("t1_pops", rd_count, 4);
    check("t1_done_pulses", done_count, 1);
    check("t1_stalls", stall_cnt, 0);

    // Two vectors then a three-cycle underflow.
    push(idx_vec(10)); push(idx_vec(11));
    rd_count = 0; done_count = 0;
    start = 1'b1; len = 8'd4;
    step();
    repeat (5) step();
    push(idx_vec(12)); push(idx_vec(13));
    run_until_idle("t2", 30);
    step();
    check("t2_pops", rd_count, 4);
    check("t2_done_pulses", done_count, 1);
    check("t2_stalls", stall_cnt, 3);

    // len=0, with a start in the DONE cycle that must be ignored.
    push(idx_vec(5));
    rd_count = 0; done_count = 0;
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b1; len = 8'd5;
    step();
    repeat (4) step();
    check("t3_pops", rd_count, 0);
    check("t3_done_pulses", done_count, 1);
    check("t3_fifo_left", fq.size(), 1);
    fq.delete(); refresh_fifo();

    // Start while streaming is ignored.
    for (int v = 0; v < 12; v++) push(VW'($urandom));
    rd_count = 0; done_count = 0;
    start = 1'b1; len = 8'd3;
    step();
    step();
    start = 1'b1; len = 8'd9;
    step();
    run_until_idle("t4", 40);
    step();
    check("t4_pops", rd_count, 3);
    check("t4_done_pulses", done_count, 1);
    check("t4_fifo_left", fq.size(), 9);
    fq.delete(); refresh_fifo();

    // Asynchronous reset two cycles into a len=6 stream.
    for (int v = 0; v < 8; v++) push(VW'($urandom));
    start = 1'b1; len = 8'd6;
    step();
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check_cleared("t5_async");
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    rd_count = 0; done_count = 0;
    repeat (10) step();
    check("t5_no_pops", rd_count, 0);
    check("t5_no_done", done_count, 0);
    check("t5_fifo_left", fq.size(), 6);
    fq.delete(); refresh_fifo();

    // Randomized streams with random FIFO arrival.
    for (int s = 0; s < 5; s++) begin
      n_len = $urandom_range(1, 20);
      pushed = $urandom_range(0, n_len);
      for (int v = 0; v < pushed; v++) push(VW'($urandom));
      rd_count = 0; done_count = 0;
      start = 1'b1; len = LW'(n_len);
      step();
      for (int i = 0; i < 300 && m_busy; i++) begin
        if (pushed < n_len && $urandom_range(0, 1) == 1) begin
          push(VW'($urandom));
          pushed++;
        end
        step();
      end
      check("rand_finished", busy, 0);
      step();
      check("rand_pops", rd_count, n_len);
      check("rand_done_pulses", done_count, 1);
    end

    // Long underflow saturates stall_cnt.
    fq.delete(); refresh_fifo();
    rd_count = 0; done_count = 0;
    start = 1'b1; len = 8'd1;
    step();
    repeat (66000) step();
    check("sat_stall", stall_cnt, 16'hFFFF);
    push(VW'($urandom));
    run_until_idle("sat", 20);
    step();
    check("sat_pops", rd_count, 1);
    check("sat_done_pulses", done_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
